spi_slave_handler: RTL and testbench

// SPI slave (mode 0, MSB first) on the command bus, peer to the spi_handler master.
// - Host preloads a TX buffer (cmd 0x14) that an external master reads over MISO.
// - Host enables upload (cmd 0x15); each byte received on MOSI is then uploaded.
// - SPI inputs are oversampled in the clk domain; spi_clk must be <= clk/8.

---
 rtl/spi_slave_handler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_spi_slave_handler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_handler.sv
// spi_slave_handler: SPI mode-0 slave (MSB first) attached to the command bus.
// The host preloads a TX buffer (cmd 0x14) that an external master reads on
// MISO, and enables upload (cmd 0x15) of bytes received on MOSI through a
// small FIFO. SPI pins are oversampled in the clk domain (spi_clk <= clk/8).
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN -- when defined, spi_miso
// is released (1'bz) while the slave is deselected so the line can be shared.
// TX_BUF_DEPTH and RX_FIFO_DEPTH are expected to be powers of two.
module spi_slave_handler #(
   parameter int         TX_BUF_DEPTH  = 256,
   parameter int         RX_FIFO_DEPTH = 16,
   parameter logic [7:0] UPLOAD_SOURCE = 8'h14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  cmd_type,
   input  logic [15:0] cmd_length,
   input  logic [7:0]  cmd_data,
   input  logic [15:0] cmd_data_index,
   input  logic        cmd_start,
   input  logic        cmd_data_valid,
   input  logic        cmd_done,
   output logic        cmd_ready,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        upload_active,
   output logic        upload_req,
   output logic [7:0]  upload_data,
   output logic [7:0]  upload_source,
   output logic        upload_valid,
   input  logic        upload_ready
);

   localparam int TX_AW = $clog2(TX_BUF_DEPTH);
   localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [15:0]    TX_DEPTH_W = 16'(TX_BUF_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_W  = (RX_AW + 1)'(RX_FIFO_DEPTH);
   localparam logic [RX_AW-1:0] PTR_ONE  = {{(RX_AW - 1){1'b0}}, 1'b1};
   localparam logic [RX_AW:0]   CNT_ONE  = {{RX_AW{1'b0}}, 1'b1};
   localparam logic [7:0] CMD_TX_LOAD   = 8'h14;
   localparam logic [7:0] CMD_UPLOAD_EN = 8'h15;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   // command side
   state_t      state_r;
   state_t      state_next_s;
   logic        cmd_ready_r;
   logic        cmd_accept_s;
   logic        tx_wr_s;
   logic        en_wr_s;
   logic [7:0]  cmd_type_r;
   logic [15:0] tx_len_r;
   logic        upload_en_r;
   logic [7:0]  tx_buf_r [TX_BUF_DEPTH];

   // SPI side: pipe[0]=first flop, pipe[1]=synced value, pipe[2]=previous synced value
   logic [2:0]  sclk_pipe_r;
   logic [2:0]  cs_pipe_r;
   logic [1:0]  mosi_pipe_r;
   logic        sclk_rise_s;
   logic        sclk_fall_s;
   logic        cs_fall_s;
   logic        cs_rise_s;
   logic        active_r;
   logic [2:0]  bit_cnt_r;
   logic [15:0] tx_ptr_r;
   logic [6:0]  tx_rem_r;
   logic [6:0]  rx_shift_r;
   logic        miso_r;
   logic [7:0]  rx_byte_s;
   logic        byte_done_s;
   logic [7:0]  first_byte_s;
   logic [7:0]  next_tx_byte_s;

   // receive FIFO
   logic [7:0]       fifo_mem_r [RX_FIFO_DEPTH];
   logic [RX_AW-1:0] wr_ptr_r;
   logic [RX_AW-1:0] rd_ptr_r;
   logic [RX_AW:0]   count_r;
   logic [RX_AW:0]   count_next_s;
   logic             valid_r;
   logic             push_s;
   logic             pop_s;

   // Command FSM state register; cmd_ready is registered from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         cmd_ready_r <= (state_next_s != ST_RECV);
      end
   end

   // Command FSM next-state and command decode strobes
   always_comb begin
      state_next_s = state_r;
      cmd_accept_s = 1'b0;
      tx_wr_s      = 1'b0;
      en_wr_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_start && ((cmd_type == CMD_TX_LOAD) || (cmd_type == CMD_UPLOAD_EN))) begin
               state_next_s = ST_RECV;
               cmd_accept_s = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            tx_wr_s = rst_n && cmd_data_valid && (cmd_type_r == CMD_TX_LOAD);
            en_wr_s = cmd_data_valid && (cmd_type_r == CMD_UPLOAD_EN) && (cmd_data_index == 16'h0000);
            if (cmd_done) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RECV;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Latch command type, TX length and upload enable
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_type_r  <= 8'h00;
         tx_len_r    <= 16'h0000;
         upload_en_r <= 1'b0;
      end else begin
         if (cmd_accept_s) begin
            cmd_type_r <= cmd_type;
            if (cmd_type == CMD_TX_LOAD) begin
               tx_len_r <= (cmd_length > TX_DEPTH_W) ? TX_DEPTH_W : cmd_length;
            end
         end
         if (en_wr_s) begin
            upload_en_r <= cmd_data[0];
         end
      end
   end

   // TX preload buffer write; the index wraps modulo the buffer depth
   always_ff @(posedge clk) begin
      if (tx_wr_s) begin
         tx_buf_r[cmd_data_index[TX_AW-1:0]] <= cmd_data;
      end
   end

   // Edge detection on synchronized SPI pins and TX byte selection
   always_comb begin
      sclk_rise_s = sclk_pipe_r[1] & ~sclk_pipe_r[2];
      sclk_fall_s = ~sclk_pipe_r[1] & sclk_pipe_r[2];
      cs_fall_s   = ~cs_pipe_r[1] & cs_pipe_r[2];
      cs_rise_s   = cs_pipe_r[1] & ~cs_pipe_r[2];
      rx_byte_s   = {rx_shift_r, mosi_pipe_r[1]};
      byte_done_s = active_r && !cs_rise_s && !cs_fall_s && sclk_rise_s && (bit_cnt_r == 3'd7);
      if (tx_len_r != 16'h0000) begin
         first_byte_s = tx_buf_r[{TX_AW{1'b0}}];
      end else begin
         first_byte_s = 8'hFF;
      end
      if (tx_ptr_r < tx_len_r) begin
         next_tx_byte_s = tx_buf_r[tx_ptr_r[TX_AW-1:0]];
      end else begin
         next_tx_byte_s = 8'hFF;
      end
   end

   // SPI synchronizers, bit counter and shift registers; CS must fall to start
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_pipe_r <= 3'b000;
         cs_pipe_r   <= 3'b000;
         mosi_pipe_r <= 2'b00;
         active_r    <= 1'b0;
         bit_cnt_r   <= 3'd0;
         tx_ptr_r    <= 16'h0000;
         tx_rem_r    <= 7'h7F;
         rx_shift_r  <= 7'h00;
         miso_r      <= 1'b1;
      end else begin
         sclk_pipe_r <= {sclk_pipe_r[1:0], spi_clk};
         cs_pipe_r   <= {cs_pipe_r[1:0], spi_cs_n};
         mosi_pipe_r <= {mosi_pipe_r[0], spi_mosi};
         if (cs_fall_s) begin
            active_r  <= 1'b1;
            bit_cnt_r <= 3'd0;
            tx_ptr_r  <= 16'h0000;
            miso_r    <= first_byte_s[7];
            tx_rem_r  <= first_byte_s[6:0];
         end else if (!active_r || cs_rise_s) begin
            active_r <= 1'b0;
            miso_r   <= 1'b1;
         end else if (sclk_rise_s) begin
            rx_shift_r <= rx_byte_s[6:0];
            if (bit_cnt_r == 3'd7) begin
               bit_cnt_r <= 3'd0;
               if (tx_ptr_r != 16'hFFFF) begin
                  tx_ptr_r <= tx_ptr_r + 16'h0001;
               end
            end else begin
               bit_cnt_r <= bit_cnt_r + 3'd1;
            end
         end else if (sclk_fall_s) begin
            if (bit_cnt_r == 3'd0) begin
               miso_r   <= next_tx_byte_s[7];
               tx_rem_r <= next_tx_byte_s[6:0];
            end else begin
               miso_r   <= tx_rem_r[6];
               tx_rem_r <= {tx_rem_r[5:0], 1'b1};
            end
         end
      end
   end

   // FIFO push/pop decisions and next occupancy
   always_comb begin
      pop_s        = valid_r && upload_ready;
      push_s       = byte_done_s && upload_en_r && ((count_r != RX_FULL_W) || pop_s);
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // FIFO pointers, occupancy and registered valid flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {RX_AW{1'b0}};
         rd_ptr_r <= {RX_AW{1'b0}};
         count_r  <= {(RX_AW + 1){1'b0}};
         valid_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
         valid_r <= (count_next_s != {(RX_AW + 1){1'b0}});
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= rx_byte_s;
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign upload_valid  = valid_r;
   assign upload_req    = valid_r;
   assign upload_active = valid_r;
   assign upload_data   = valid_r ? fifo_mem_r[rd_ptr_r] : 8'h00;
   assign upload_source = UPLOAD_SOURCE;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   assign spi_miso = active_r ? miso_r : 1'bz;
`else
   assign spi_miso = miso_r;
`endif

endmodule

// File: tb/tb_spi_slave_handler.sv
// Directed bench for spi_slave_handler: command bus preload/enable, SPI
// master transfers in mode 0, upload FIFO draining, overflow and CS abort.
`timescale 1ns/1ps
module tb_spi_slave_handler;

   localparam int SPI_HALF = 250;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cmd_type = 8'h00;
   logic [15:0] cmd_length = 16'h0000;
   logic [7:0]  cmd_data = 8'h00;
   logic [15:0] cmd_data_index = 16'h0000;
   logic        cmd_start = 1'b0;
   logic        cmd_data_valid = 1'b0;
   logic        cmd_done = 1'b0;
   logic        cmd_ready;
   logic        spi_clk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        upload_active;
   logic        upload_req;
   logic [7:0]  upload_data;
   logic [7:0]  upload_source;
   logic        upload_valid;
   logic        upload_ready = 1'b0;

   int total = 0;
   int bad = 0;
   logic [7:0] up_q[$];
   int valid_seen = 0;

   spi_slave_handler dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
      .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
      .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
      .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .upload_active(upload_active), .upload_req(upload_req), .upload_data(upload_data),
      .upload_source(upload_source), .upload_valid(upload_valid), .upload_ready(upload_ready)
   );

   always #5 clk = ~clk;

   // record every accepted upload byte and every cycle with valid high
   always @(negedge clk) begin
      if (upload_valid) valid_seen++;
      if (upload_valid && upload_ready) up_q.push_back(upload_data);
   end

   task automatic cmd_send(input logic [7:0] t, input logic [15:0] len,
                           input logic [63:0] pl, input int n, output logic rdy_after_start);
      @(posedge clk); #1;
      cmd_type = t; cmd_length = len; cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      rdy_after_start = cmd_ready;
      for (int i = 0; i < n; i++) begin
         cmd_data = pl[63-8*i -: 8]; cmd_data_index = 16'(i); cmd_data_valid = 1'b1;
         @(posedge clk); #1;
         cmd_data_valid = 1'b0;
      end
      cmd_done = 1'b1;
      @(posedge clk); #1;
      cmd_done = 1'b0;
   endtask

   task automatic spi_cs_lo();
      spi_cs_n = 1'b0;
      #(SPI_HALF);
   endtask

   task automatic spi_cs_hi();
      #(SPI_HALF);
      spi_cs_n = 1'b1;
      #(SPI_HALF);
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = tx[i];
         #(SPI_HALF);
         spi_clk = 1'b1;
         rx[i] = spi_miso;
         #(SPI_HALF);
         spi_clk = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic rdy;
      rst_n = 1'b0;
      repeat (4) @(posedge clk); #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      total++; if (upload_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", upload_valid); end
      total++; if ({upload_req, upload_active} !== 2'b00) begin bad++; $display("FAIL reset_req_active got=%b exp=00", {upload_req, upload_active}); end
      total++; if (upload_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", upload_data); end
      total++; if (upload_source !== 8'h14) begin bad++; $display("FAIL reset_source got=%h exp=14", upload_source); end
      total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b exp=1", spi_miso); end
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      cmd_send(8'h33, 16'h0001, 64'h0, 1, rdy);
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ignored_cmd_ready got=%b exp=1", rdy); end
   endtask

   task automatic test_upload();
      logic rdy;
      logic [7:0] rx;
      logic [31:0] pat;
      int base;
      pat = 32'hAABBCCDD;
      cmd_send(8'h15, 16'h0001, 64'h0100000000000000, 1, rdy);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL recv_cmd_ready got=%b exp=0", rdy); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
      upload_ready = 1'b1;
      base = up_q.size();
      spi_cs_lo();
      for (int i = 0; i < 4; i++) begin
         spi_byte(pat[31-8*i -: 8], 8, rx);
         total++; if (rx !== 8'hFF) begin bad++; $display("FAIL empty_tx_miso byte=%0d got=%h exp=ff", i, rx); end
      end
      spi_cs_hi();
      repeat (10) @(posedge clk); #1;
      total++; if (up_q.size() - base !== 4) begin bad++; $display("FAIL upload_count got=%0d exp=4", up_q.size() - base); end
      for (int i = 0; i < 4; i++) begin
         total++; if (up_q[base+i] !== pat[31-8*i -: 8]) begin bad++; $display("FAIL upload_byte%0d got=%h exp=%h", i, up_q[base+i], pat[31-8*i -: 8]); end
      end
      total++; if (upload_source !== 8'h14) begin bad++; $display("FAIL upload_source got=%h exp=14", upload_source); end
      total++; if (upload_valid !== 1'b0) begin bad++; $display("FAIL drained_valid got=%b exp=0", upload_valid); end
   endtask

   task automatic test_upload_disabled();
      logic rdy;
      logic [7:0] rx;
      int vbase;
      int qbase;
      cmd_send(8'h15, 16'h0001, 64'h0, 1, rdy);
      vbase = valid_seen;
      qbase = up_q.size();
      spi_cs_lo();
      spi_byte(8'h11, 8, rx);
      spi_byte(8'h22, 8, rx);
      spi_byte(8'h33, 8, rx);
      spi_cs_hi();
      repeat (10) @(posedge clk); #1;
      total++; if (valid_seen !== vbase) begin bad++; $display("FAIL disabled_valid_cycles got=%0d exp=0", valid_seen - vbase); end
      total++; if (up_q.size() !== qbase) begin bad++; $display("FAIL disabled_uploads got=%0d exp=0", up_q.size() - qbase); end
   endtask

   task automatic test_tx_readback();
      logic rdy;
      logic [7:0] rx;
      logic [7:0] exp;
      logic [63:0] pl;
      pl = 64'h4650474132303235;
      cmd_send(8'h14, 16'h0008, pl, 8, rdy);
      spi_cs_lo();
      for (int i = 0; i < 10; i++) begin
         spi_byte(8'h00, 8, rx);
         exp = (i < 8) ? pl[63-8*i -: 8] : 8'hFF;
         total++; if (rx !== exp) begin bad++; $display("FAIL tx_byte%0d got=%h exp=%h", i, rx, exp); end
      end
      spi_cs_hi();
      repeat (4) @(posedge clk); #1;
      total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL cs_high_miso got=%b exp=1", spi_miso); end
   endtask

   task automatic test_fifo_overflow();
      logic rdy;
      logic [7:0] rx;
      int qbase;
      cmd_send(8'h15, 16'h0001, 64'h0100000000000000, 1, rdy);
      upload_ready = 1'b0;
      qbase = up_q.size();
      spi_cs_lo();
      for (int i = 0; i < 20; i++) spi_byte(8'h10 + 8'(i), 8, rx);
      spi_cs_hi();
      repeat (5) @(posedge clk); #1;
      total++; if ({upload_valid, upload_req, upload_active} !== 3'b111) begin bad++; $display("FAIL full_flags got=%b exp=111", {upload_valid, upload_req, upload_active}); end
      total++; if (upload_data !== 8'h10) begin bad++; $display("FAIL full_head got=%h exp=10", upload_data); end
      total++; if (up_q.size() !== qbase) begin bad++; $display("FAIL held_uploads got=%0d exp=0", up_q.size() - qbase); end
      @(posedge clk); #1;
      upload_ready = 1'b1;
      repeat (16) @(posedge clk); #1;
      total++; if (upload_valid !== 1'b0) begin bad++; $display("FAIL drain_16_cycles_valid got=%b exp=0", upload_valid); end
      total++; if (up_q.size() - qbase !== 16) begin bad++; $display("FAIL drain_count got=%0d exp=16", up_q.size() - qbase); end
      for (int i = 0; i < 16; i++) begin
         total++; if (up_q[qbase+i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_byte%0d got=%h exp=%h", i, up_q[qbase+i], 8'h10 + 8'(i)); end
      end
   endtask

   task automatic test_cs_abort();
      logic [7:0] rx;
      int qbase;
      qbase = up_q.size();
      spi_cs_lo();
      spi_byte(8'hF0, 5, rx);
      spi_cs_hi();
      repeat (10) @(posedge clk); #1;
      total++; if (up_q.size() !== qbase) begin bad++; $display("FAIL partial_uploads got=%0d exp=0", up_q.size() - qbase); end
      total++; if (upload_valid !== 1'b0) begin bad++; $display("FAIL partial_valid got=%b exp=0", upload_valid); end
      spi_cs_lo();
      spi_byte(8'h5A, 8, rx);
      spi_cs_hi();
      repeat (10) @(posedge clk); #1;
      total++; if (rx !== 8'h46) begin bad++; $display("FAIL restart_tx_byte got=%h exp=46", rx); end
      total++; if (up_q.size() - qbase !== 1) begin bad++; $display("FAIL restart_uploads got=%0d exp=1", up_q.size() - qbase); end
      total++; if (up_q[qbase] !== 8'h5A) begin bad++; $display("FAIL restart_upload_byte got=%h exp=5a", up_q[qbase]); end
   endtask

   initial begin
      test_reset();
      test_upload();
      test_upload_disabled();
      test_tx_readback();
      test_fifo_overflow();
      test_cs_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
